// File: rtl/display_mode_controller.sv
// display_mode_controller: alarm-clock front-panel mode sequencer with edit-field blink and idle timeout
module display_mode_controller #(
  parameter int CLKS_PER_SEC = 100_000_000,
  parameter int TIMEOUT_SEC  = 10
) (
  input  logic i_Clk,
  input  logic i_Reset_N,
  input  logic i_Mode_Pulse,
  input  logic i_Set_Pulse,
  input  logic i_Up_Pulse,
  output logic o_Display_Sel,
  output logic o_Target_Alarm,
  output logic o_Inc_Hour,
  output logic o_Inc_Min,
  output logic o_Time_Hold,
  output logic o_Blank_Hour,
  output logic o_Blank_Min
);
  localparam longint IDLE_CYCLES = longint'(CLKS_PER_SEC) * longint'(TIMEOUT_SEC);
  localparam int IW = $clog2(IDLE_CYCLES);
  localparam int BW = $clog2(CLKS_PER_SEC);
  typedef enum logic [2:0] {SHOW_TIME, SHOW_ALARM, SET_T_HR, SET_T_MIN, SET_A_HR, SET_A_MIN} state_t;
  state_t state, state_n;
  logic [IW-1:0] idle, idle_n;
  logic [BW-1:0] blink, blink_n;
  logic set, mode, up, any, timeout, in_set, ns_hr, ns_min, ns_alarm, inc_up, enter_set;
  always_comb begin
    set = i_Set_Pulse;
    mode = ~i_Set_Pulse & i_Mode_Pulse;
    up = ~i_Set_Pulse & ~i_Mode_Pulse & i_Up_Pulse;
    any = i_Set_Pulse | i_Mode_Pulse | i_Up_Pulse;
    timeout = idle == IW'(IDLE_CYCLES - 1);
    in_set = state inside {SET_T_HR, SET_T_MIN, SET_A_HR, SET_A_MIN};
    state_n = state;
    case (state)
      SHOW_TIME:  state_n = set ? SET_T_HR : mode ? SHOW_ALARM : state;
      SHOW_ALARM: state_n = set ? SET_A_HR : mode ? SHOW_TIME : state;
      SET_T_HR:   state_n = set ? SET_T_MIN : mode ? SHOW_TIME : state;
      SET_A_HR:   state_n = set ? SET_A_MIN : mode ? SHOW_TIME : state;
      default:    state_n = (set | mode) ? SHOW_TIME : state;
    endcase
    // any pulse in the same cycle wins over the idle timeout
    if (!any && timeout) state_n = SHOW_TIME;
    inc_up = up & in_set;
    ns_hr = state_n inside {SET_T_HR, SET_A_HR};
    ns_min = state_n inside {SET_T_MIN, SET_A_MIN};
    ns_alarm = state_n inside {SHOW_ALARM, SET_A_HR, SET_A_MIN};
    enter_set = (ns_hr | ns_min) && state_n != state;
    idle_n = (state_n == SHOW_TIME || any) ? '0 : idle + IW'(1);
    blink_n = (enter_set || inc_up || blink == BW'(CLKS_PER_SEC - 1)) ? '0 : blink + BW'(1);
  end
  always_ff @(posedge i_Clk or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state <= SHOW_TIME;
      idle <= '0;
      blink <= '0;
      o_Display_Sel <= 1'b0;
      o_Target_Alarm <= 1'b0;
      o_Inc_Hour <= 1'b0;
      o_Inc_Min <= 1'b0;
      o_Time_Hold <= 1'b0;
      o_Blank_Hour <= 1'b0;
      o_Blank_Min <= 1'b0;
    end else begin
      state <= state_n;
      idle <= idle_n;
      blink <= blink_n;
      o_Display_Sel <= ns_alarm;
      o_Target_Alarm <= state_n inside {SET_A_HR, SET_A_MIN};
      o_Inc_Hour <= inc_up & (state inside {SET_T_HR, SET_A_HR});
      o_Inc_Min <= inc_up & (state inside {SET_T_MIN, SET_A_MIN});
      o_Time_Hold <= state_n inside {SET_T_HR, SET_T_MIN};
      o_Blank_Hour <= ns_hr & (blink_n >= BW'(CLKS_PER_SEC / 2));
      o_Blank_Min <= ns_min & (blink_n >= BW'(CLKS_PER_SEC / 2));
    end
  end
endmodule

// File: tb/tb_display_mode_controller.sv
// tb_display_mode_controller: directed vector table plus multi-cycle timeout, blink and reset sequences
module tb_display_mode_controller;
  logic clk = 0, rst_n = 0, s = 0, m = 0, u = 0;
  logic disp, tgt, ih, im, hold, bh, bm;
  int checks = 0, failures = 0;
  display_mode_controller #(.CLKS_PER_SEC(10), .TIMEOUT_SEC(3)) dut (
    .i_Clk(clk), .i_Reset_N(rst_n), .i_Mode_Pulse(m), .i_Set_Pulse(s), .i_Up_Pulse(u),
    .o_Display_Sel(disp), .o_Target_Alarm(tgt), .o_Inc_Hour(ih), .o_Inc_Min(im),
    .o_Time_Hold(hold), .o_Blank_Hour(bh), .o_Blank_Min(bm)
  );
  always #5 clk = ~clk;
  typedef struct {bit s; bit m; bit u; logic [6:0] exp; string nm;} vec_t;
  vec_t v[18];
  function automatic logic [6:0] outs();
    return {disp, tgt, ih, im, hold, bh, bm};
  endfunction
  task automatic check(input string nm, input logic [6:0] exp);
    checks++;
    if (outs() !== exp) begin
      failures++;
      $display("FAIL %s got={sel,tgt,ih,im,hold,bh,bm}=%b exp=%b", nm, outs(), exp);
    end
  endtask
  task automatic tick(input bit ts, input bit tm, input bit tu);
    s = ts; m = tm; u = tu;
    @(posedge clk); #1;
    s = 0; m = 0; u = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    // outputs are {sel,tgt,ih,im,hold,bh,bm}
    v[0]  = '{0,0,0,7'b0000000,"reset_idle"};
    v[1]  = '{0,1,0,7'b1000000,"mode_to_alarm"};
    v[2]  = '{0,1,0,7'b0000000,"mode_to_time"};
    v[3]  = '{1,0,0,7'b0000100,"set_t_hr"};
    v[4]  = '{0,0,1,7'b0010100,"inc_hr1"};
    v[5]  = '{0,0,0,7'b0000100,"inc_hr_gap"};
    v[6]  = '{0,0,1,7'b0010100,"inc_hr2"};
    v[7]  = '{0,0,1,7'b0010100,"inc_hr3"};
    v[8]  = '{1,0,0,7'b0000100,"set_t_min"};
    v[9]  = '{0,0,1,7'b0001100,"inc_min1"};
    v[10] = '{0,0,1,7'b0001100,"inc_min2"};
    v[11] = '{1,0,0,7'b0000000,"set_done"};
    v[12] = '{0,1,0,7'b1000000,"alarm_view"};
    v[13] = '{1,0,0,7'b1100000,"set_a_hr"};
    v[14] = '{0,0,1,7'b1110000,"alarm_inc_hr"};
    v[15] = '{0,1,0,7'b0000000,"abort"};
    v[16] = '{1,1,1,7'b0000100,"prio_set"};
    v[17] = '{0,1,1,7'b0000000,"prio_mode"};
    #12;
    check("reset_async", 7'b0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      tick(v[i].s, v[i].m, v[i].u);
      check(v[i].nm, v[i].exp);
    end
    tick(1, 0, 0);
    check("blink_enter", 7'b0000100);
    for (int k = 1; k <= 17; k++) begin
      tick(0, 0, 0);
      check("blink_phase", {4'b0000, 1'b1, (k % 10) >= 5, 1'b0});
    end
    tick(0, 0, 1);
    check("blink_up_clear", 7'b0010100);
    for (int k = 1; k <= 5; k++) begin
      tick(0, 0, 0);
      check("blink_after_up", {4'b0000, 1'b1, k >= 5, 1'b0});
    end
    tick(0, 1, 0);
    check("blink_exit", 7'b0000000);
    tick(0, 1, 0);
    for (int k = 1; k <= 30; k++) begin
      tick(0, 0, 0);
      check("timeout_alarm", {k < 30, 6'b0});
    end
    tick(0, 1, 0);
    for (int k = 1; k <= 59; k++) begin
      tick(0, 0, k == 29);
      check("timeout_up29", {k < 59, 6'b0});
    end
    tick(0, 1, 0);
    for (int k = 1; k <= 60; k++) begin
      tick(0, 0, k == 30);
      check("pulse_beats_timeout", {k < 60, 6'b0});
    end
    tick(1, 0, 0);
    tick(0, 0, 1);
    check("set_timeout_inc", 7'b0010100);
    for (int k = 1; k <= 30; k++) begin
      tick(0, 0, 0);
      check("timeout_set", {4'b0000, k < 30, (k < 30) && (k % 10) >= 5, 1'b0});
    end
    tick(0, 1, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    check("enter_set_a_min", 7'b1100000);
    for (int k = 1; k <= 7; k++) begin
      tick(0, 0, 0);
      check("a_min_blink", {2'b11, 4'b0000, k >= 5});
    end
    #2 rst_n = 0; u = 1;
    #1 check("reset_mid_edit", 7'b0);
    @(posedge clk); #1;
    check("reset_held_no_strobe", 7'b0);
    u = 0;
    #3 rst_n = 1;
    @(posedge clk); #1;
    check("reset_release", 7'b0);
    tick(0, 1, 0);
    check("after_reset_mode", 7'b1000000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
